// File: rtl/mult_pipe_accum.sv
// Burst accumulator behind the pipelined multiplier: tag delay line, sticky-overflow sum, valid/ready result.
// Define MULT_PIPE_ACCUM_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module mult_pipe_accum #(
    parameter int PROD_WIDTH  = 4,
    parameter int ACC_WIDTH   = 12,
    parameter int NUM_STAGES  = 2,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   in_valid,
    input  logic                   in_last,
    input  logic                   tc,
    input  logic [PROD_WIDTH-1:0]  product,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [ACC_WIDTH-1:0]   out_sum,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic                   out_ovf,
    output logic                   stall
);

    localparam int DEPTH = NUM_STAGES - 1;
    localparam int MSB   = ACC_WIDTH - 1;

    typedef struct packed {
        logic vld;
        logic last;
        logic tc;
    } tag_t;

    typedef enum logic {IDLE, ACCUM} state_t;

    tag_t [DEPTH-1:0] tag_pipe;
    tag_t             tail;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d, acc_next;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, cnt_next;
    logic                   ovf_q, ovf_d;
    logic                   ovf_term;
    logic                   absorb;
    logic                   load_result;
    logic [ACC_WIDTH-1:0]   prod_ext;
    logic [ACC_WIDTH:0]     sum_full;

    // Tags ride alongside the multiplier pipeline so the tail lines up with `product`.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_pipe <= '0;
        end else if (en) begin
            tag_pipe[0] <= {in_valid, in_last, tc};
            for (int i = 1; i < DEPTH; i++)
                tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign tail   = tag_pipe[DEPTH-1];
    assign absorb = en & tail.vld;

    assign prod_ext = tail.tc ? ACC_WIDTH'($signed(product)) : ACC_WIDTH'(product);
    assign sum_full = {1'b0, acc_q} + {1'b0, prod_ext};

    always_comb begin
        ovf_term = tail.tc ? ((acc_q[MSB] == prod_ext[MSB]) && (sum_full[MSB] != acc_q[MSB]))
                           : sum_full[ACC_WIDTH];
        acc_next = sum_full[ACC_WIDTH-1:0];
`ifdef MULT_PIPE_ACCUM_SAT_EN
        // Signed overflow only happens with like-signed operands, so acc's sign picks the rail.
        if (ovf_term)
            acc_next = tail.tc ? (acc_q[MSB] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                             : {1'b0, {(ACC_WIDTH-1){1'b1}}})
                               : '1;
`endif
        cnt_next = (&cnt_q) ? cnt_q : cnt_q + COUNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        load_result = 1'b0;
        case (state_q)
            IDLE: begin
                if (absorb && !tail.last) begin
                    state_d = ACCUM;
                    acc_d   = acc_next;
                    cnt_d   = cnt_next;
                    ovf_d   = ovf_term;
                end else if (absorb) begin
                    load_result = 1'b1;
                end
            end
            ACCUM: begin
                if (absorb && tail.last) begin
                    state_d     = IDLE;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    load_result = 1'b1;
                end else if (absorb) begin
                    acc_d = acc_next;
                    cnt_d = cnt_next;
                    ovf_d = ovf_q | ovf_term;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A new result may land on the same edge the old one is taken, keeping out_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (load_result) begin
            out_valid <= 1'b1;
            out_sum   <= acc_next;
            out_count <= cnt_next;
            out_ovf   <= ovf_q | ovf_term;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign stall = out_valid & ~out_ready;

endmodule

// File: tb/tb_mult_pipe_accum.sv
// Randomized + directed bench for mult_pipe_accum with a burst-level integer reference model and result scoreboard.
module tb_mult_pipe_accum;
    localparam int PW = 4, AW = 6, NS = 2, CW = 4, D = NS - 1;
    localparam int LIM = 1 << AW, HALF = LIM / 2, CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n, en, in_valid, in_last, tc, out_ready;
    logic [PW-1:0] product;
    logic out_valid, out_ovf, stall;
    logic [AW-1:0] out_sum;
    logic [CW-1:0] out_count;

    logic [1:0] op_a, op_b;
    logic [PW-1:0] prod_dly [D];

    typedef struct {int sum; int cnt; bit ovf;} res_t;
    res_t sb_q[$];
    res_t mon_e;
    int m_acc, m_cnt;
    bit m_ovf;
    int n_vec = 0, n_err = 0;
    bit iss;

    mult_pipe_accum #(.PROD_WIDTH(PW), .ACC_WIDTH(AW), .NUM_STAGES(NS), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_last(in_last), .tc(tc),
        .product(product), .out_ready(out_ready), .out_valid(out_valid), .out_sum(out_sum),
        .out_count(out_count), .out_ovf(out_ovf), .stall(stall));

    always #5 clk = ~clk;

    function automatic int opv(input logic [1:0] x, input bit t);
        return (t && x[1]) ? int'(x) - 4 : int'(x);
    endfunction

    // Stand-in for the upstream multiplier: NUM_STAGES-1 cycles of latency, gated by en.
    always @(posedge clk) begin
        if (en) begin
            for (int i = D - 1; i > 0; i--) prod_dly[i] <= prod_dly[i-1];
            prod_dly[0] <= PW'(opv(op_a, tc) * opv(op_b, tc));
        end
    end
    assign product = prod_dly[D-1];

    task automatic model_issue(input logic [1:0] a, input logic [1:0] b, input bit t, input bit l);
        int v, r, s;
        bit o;
        v = opv(a, t) * opv(b, t);
        if (t) begin
            s = (m_acc >= HALF) ? m_acc - LIM : m_acc;
            r = s + v;
            o = (r > HALF - 1) || (r < -HALF);
        end else begin
            r = m_acc + v;
            o = r > LIM - 1;
        end
`ifdef MULT_PIPE_ACCUM_SAT_EN
        if (o) r = t ? ((r > 0) ? HALF - 1 : -HALF) : LIM - 1;
`endif
        m_acc = r & (LIM - 1);
        m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
        m_ovf = m_ovf | o;
        if (l) begin
            sb_q.push_back('{m_acc, m_cnt, m_ovf});
            m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One cycle of stimulus; en is suppressed while stall is high, as upstream would do.
    task automatic cyc(input bit v, input bit l, input bit t, input logic [1:0] a, input logic [1:0] b,
                       input bit en_req, input bit rdy, output bit issued);
        @(negedge clk);
        out_ready = rdy; in_valid = v; in_last = l; tc = t; op_a = a; op_b = b;
        #1;
        en = en_req & ~stall;
        issued = en & v;
        if (issued) model_issue(a, b, t, l);
    endtask

    task automatic term(input logic [1:0] a, input logic [1:0] b, input bit t, input bit l);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) cyc(1'b1, l, t, a, b, 1'b1, 1'b1, ok);
        if (!ok) chk("term_issue_timeout", 0, 1);
    endtask

    task automatic drain();
        bit dummy;
        for (int i = 0; i < 60 && (sb_q.size() != 0 || out_valid); i++) begin
            cyc(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, dummy);
            #2;
        end
        chk("drain_pending", sb_q.size(), 0);
    endtask

    // Scoreboard monitor: a handshake completes on the coming edge when valid and ready are both high.
    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid && out_ready) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL result_unexpected: got sum=%0d count=%0d ovf=%0d, nothing expected",
                         out_sum, out_count, out_ovf);
            end else begin
                mon_e = sb_q.pop_front();
                if (out_sum !== AW'(mon_e.sum) || out_count !== CW'(mon_e.cnt) || out_ovf !== mon_e.ovf) begin
                    n_err++;
                    $display("FAIL result: got sum=%0d count=%0d ovf=%0d expected sum=%0d count=%0d ovf=%0d",
                             out_sum, out_count, out_ovf, mon_e.sum, mon_e.cnt, mon_e.ovf);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_last = 1'b0; tc = 1'b0;
        out_ready = 1'b0; op_a = '0; op_b = '0;
        m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_sum", out_sum, 0);
        chk("rst_count", out_count, 0);
        chk("rst_ovf", out_ovf, 0);
        chk("rst_stall", stall, 0);
        @(negedge clk) rst_n = 1'b1;

        // Unsigned burst (12), signed burst (-1), wrapping/clamping overflow, count saturation.
        term(2'd3, 2'd3, 1'b0, 1'b0); term(2'd2, 2'd1, 1'b0, 1'b0); term(2'd1, 2'd1, 1'b0, 1'b1);
        term(2'd2, 2'd1, 1'b1, 1'b0); term(2'd3, 2'd3, 1'b1, 1'b1);
        repeat (7) term(2'd3, 2'd3, 1'b0, 1'b0);
        term(2'd3, 2'd3, 1'b0, 1'b1);
        repeat (19) term(2'd1, 2'd1, 1'b0, 1'b0);
        term(2'd1, 2'd1, 1'b0, 1'b1);
        term(2'd2, 2'd2, 1'b1, 1'b1);
        drain();

        // Latency with three en bubbles after the last term.
        cyc(1'b1, 1'b1, 1'b0, 2'd2, 2'd3, 1'b1, 1'b1, iss);
        chk("lat_issue", iss, 1);
        @(posedge clk); #1;
        chk("lat_e0_valid", out_valid, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 2'd3, 2'd3, 1'b0, 1'b1, iss);
            @(posedge clk); #1;
            chk("lat_bubble_valid", out_valid, 0);
        end
        for (int k = 1; k <= D; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, iss);
            @(posedge clk); #1;
            chk("lat_valid", out_valid, (k == D) ? 1 : 0);
        end
        drain();

        // Backpressure: hold result 9, with result 2 waiting at the tail.
        cyc(1'b1, 1'b1, 1'b0, 2'd3, 2'd3, 1'b1, 1'b0, iss);
        cyc(1'b1, 1'b1, 1'b0, 2'd2, 2'd1, 1'b1, 1'b0, iss);
        for (int k = 1; k < D; k++) cyc(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, iss);
        @(posedge clk); #1;
        chk("bp_valid", out_valid, 1);
        chk("bp_queue", sb_q.size(), 2);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 2'd1, 2'd1, 1'b1, 1'b0, iss);
            @(posedge clk); #1;
            chk("bp_stall", stall, 1);
            chk("bp_hold_valid", out_valid, 1);
            if (sb_q.size() > 0) chk("bp_hold_sum", out_sum, sb_q[0].sum);
        end
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, iss);
        @(posedge clk); #1;
        chk("bp_reload_valid", out_valid, 1);
        chk("bp_reload_queue", sb_q.size(), 1);
        if (sb_q.size() > 0) chk("bp_reload_sum", out_sum, sb_q[0].sum);
        drain();

        // Reset mid-burst after two absorbed terms.
        term(2'd3, 2'd2, 1'b0, 1'b0); term(2'd1, 2'd2, 1'b0, 1'b0);
        for (int k = 0; k < D; k++) cyc(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, iss);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_sum", out_sum, 0);
        chk("mid_rst_count", out_count, 0);
        chk("mid_rst_ovf", out_ovf, 0);
        sb_q.delete();
        m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        term(2'd2, 2'd2, 1'b0, 1'b1);
        drain();

        // Random traffic with en bubbles, backpressure, and mixed tc.
        for (int n = 0; n < 500; n++) begin
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                $urandom_range(0, 4) != 0, $urandom_range(0, 9) < 7, iss);
        end
        term(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
